// File: rtl/tick_timer_pkg.sv
// Shared types and constants for the tick timer and its synchroniser.
// State encoding, warm-up length and synchroniser depth live here.
package tick_timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int WARMUP_CYCLES = 2;
    localparam int SYNC_STAGES   = 2;

endpackage

// File: rtl/tick_sync.sv
// Synchronises the divider output and emits a registered one-cycle pulse per rising edge.
// Rise sampled at edge k shows as tick_pulse after edge k+2; no backpressure, free-running.
module tick_sync (
    input  logic clk,
    input  logic rstn,
    input  logic tick_in,
    output logic tick_pulse
);
    import tick_timer_pkg::*;

    localparam logic [1:0] WARM_DONE = 2'(WARMUP_CYCLES);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_s2_d;
    logic [1:0]             r_warm;
    logic                   r_primed;
    logic                   r_tick_pulse;
    logic                   w_s2;
    logic                   w_rise;

    assign w_s2   = r_sync[SYNC_STAGES-1];
    assign w_rise = w_s2 & ~r_s2_d & r_primed;

    // primed rises one edge after the counter saturates, so a tick_in held high
    // through reset cannot produce an edge once the gate opens.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync       <= '0;
            r_s2_d       <= 1'b0;
            r_warm       <= 2'd0;
            r_primed     <= 1'b0;
            r_tick_pulse <= 1'b0;
        end else begin
            r_sync       <= {r_sync[SYNC_STAGES-2:0], tick_in};
            r_s2_d       <= w_s2;
            r_tick_pulse <= w_rise;
            if (r_warm != WARM_DONE) begin
                r_warm <= r_warm + 2'd1;
            end
            if (r_warm == WARM_DONE) begin
                r_primed <= 1'b1;
            end
        end
    end

    assign tick_pulse = r_tick_pulse;

endmodule

// File: rtl/tick_timer.sv
// Interval timer: counts load_val synchronised ticks after start, pulses done on completion.
// busy from the start edge, done one cycle after the final tick's edge; start ignored while busy.
module tick_timer #(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               tick_in,
    input  logic               start,
    input  logic [COUNT_W-1:0] load_val,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] remaining,
    output logic               tick_pulse
);
    import tick_timer_pkg::*;

    localparam logic [COUNT_W-1:0] ONE = COUNT_W'(1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [COUNT_W-1:0] r_remaining;
    logic [COUNT_W-1:0] w_remaining_nxt;
    logic               w_tick;

    tick_sync u_tick_sync (
        .clk        (clk),
        .rstn       (rstn),
        .tick_in    (tick_in),
        .tick_pulse (w_tick)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_remaining <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (load_val != '0) begin
                        w_remaining_nxt = load_val;
                        w_state_nxt     = COUNT;
                    end else begin
                        w_state_nxt     = DONE;
                    end
                end
            end
            COUNT: begin
                // abort wins over a tick arriving on the same edge
                if (abort) begin
                    w_remaining_nxt = '0;
                    w_state_nxt     = IDLE;
                end else if (w_tick && (r_remaining != '0)) begin
                    w_remaining_nxt = r_remaining - ONE;
                    if (r_remaining == ONE) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt     = IDLE;
                w_remaining_nxt = '0;
            end
        endcase
    end

    assign busy       = (r_state != IDLE);
    assign done       = (r_state == DONE);
    assign remaining  = r_remaining;
    assign tick_pulse = w_tick;

endmodule

// File: tb/tb_tick_timer.sv
// Bench for tick_timer: per-cycle comparison against a behavioural model plus directed literal checks.
module tb_tick_timer;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rstn;
    logic         tick_in;
    logic         start;
    logic         abort;
    logic [W-1:0] load_val;
    logic         busy;
    logic         done;
    logic         tick_pulse;
    logic [W-1:0] remaining;

    int checks     = 0;
    int passed     = 0;
    int pulse_seen = 0;
    int done_seen  = 0;
    int p0;
    int d0;

    // model: edges since reset release, tick_in history at recent edges, timer mode
    int m_edge = 0;
    int m_mode = 0;
    int m_rem  = 0;
    bit m_pulse = 1'b0;
    bit m_prev_pulse;
    bit h0 = 1'b0, h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;

    always #5 clk = ~clk;

    tick_timer #(.COUNT_W(W)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .tick_in    (tick_in),
        .start      (start),
        .load_val   (load_val),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .remaining  (remaining),
        .tick_pulse (tick_pulse)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic rise4();
        tick_in = 1'b1;
        cyc(4);
    endtask

    task automatic finish_tick();
        cyc(28);
        tick_in = 1'b0;
        cyc(32);
    endtask

    // Model update and comparison, 1 time unit after each edge (inputs still hold sampled values).
    always @(posedge clk) begin
        #1;
        if (!rstn) begin
            m_edge = 0; m_mode = 0; m_rem = 0; m_pulse = 1'b0;
            h0 = 1'b0; h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
        end else begin
            m_edge++;
            h3 = h2; h2 = h1; h1 = h0; h0 = tick_in;
            m_prev_pulse = m_pulse;
            case (m_mode)
                0: if (start) begin
                    if (load_val != 0) begin m_rem = int'(load_val); m_mode = 1; end
                    else m_mode = 2;
                end
                1: if (abort) begin
                    m_mode = 0; m_rem = 0;
                end else if (m_prev_pulse && m_rem > 0) begin
                    m_rem = m_rem - 1;
                    if (m_rem == 0) m_mode = 2;
                end
                default: m_mode = 0;
            endcase
            // a rise first seen at edge n-2 pulses at edge n, unless still in warm-up
            m_pulse = h2 && !h3 && (m_edge >= 4);
        end
        chk("tick_pulse", int'(tick_pulse), int'(m_pulse));
        chk("busy", int'(busy), int'(m_mode != 0));
        chk("done", int'(done), int'(m_mode == 2));
        chk("remaining", int'(remaining), m_rem);
        if (tick_pulse) pulse_seen++;
        if (done) done_seen++;
    end

    initial begin
        rstn = 1'b0; tick_in = 1'b1; start = 1'b0; abort = 1'b0; load_val = '0;
        #2;
        cyc(3);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_remaining", int'(remaining), 0);
        chk("rst_pulse", int'(tick_pulse), 0);
        rstn = 1'b1;
        p0 = pulse_seen;
        cyc(10);
        chk("warmup_no_pulse", pulse_seen - p0, 0);
        tick_in = 1'b0;
        cyc(32);

        // normal count of 3
        d0 = done_seen;
        start = 1'b1; load_val = 8'd3; cyc(1); start = 1'b0;
        chk("norm_busy", int'(busy), 1);
        chk("norm_rem3", int'(remaining), 3);
        rise4(); chk("norm_rem2", int'(remaining), 2); finish_tick();
        rise4(); chk("norm_rem1", int'(remaining), 1); finish_tick();
        rise4();
        chk("norm_rem0", int'(remaining), 0);
        chk("norm_done", int'(done), 1);
        chk("norm_busy_done", int'(busy), 1);
        cyc(1);
        chk("norm_done_off", int'(done), 0);
        chk("norm_busy_off", int'(busy), 0);
        chk("norm_done_count", done_seen - d0, 1);
        finish_tick();

        // zero load
        start = 1'b1; load_val = 8'd0; cyc(1); start = 1'b0;
        chk("zero_done", int'(done), 1);
        chk("zero_busy", int'(busy), 1);
        chk("zero_rem", int'(remaining), 0);
        cyc(1);
        chk("zero_busy_off", int'(busy), 0);

        // abort on the 2nd tick, then a 1-tick count
        d0 = done_seen;
        start = 1'b1; load_val = 8'd5; cyc(1); start = 1'b0;
        rise4(); chk("abort_rem4", int'(remaining), 4); finish_tick();
        tick_in = 1'b1; cyc(3);
        chk("abort_pulse_now", int'(tick_pulse), 1);
        abort = 1'b1; cyc(1); abort = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_rem", int'(remaining), 0);
        cyc(3);
        chk("abort_no_done", done_seen - d0, 0);
        finish_tick();
        start = 1'b1; load_val = 8'd1; cyc(1); start = 1'b0;
        rise4();
        chk("after_abort_done", int'(done), 1);
        chk("after_abort_rem", int'(remaining), 0);
        finish_tick();

        // start while counting is ignored
        start = 1'b1; load_val = 8'd4; cyc(1);
        load_val = 8'd9; cyc(1); start = 1'b0;
        chk("ign_rem4", int'(remaining), 4);
        chk("ign_busy", int'(busy), 1);
        for (int i = 0; i < 4; i++) begin
            rise4();
            chk("ign_rem_step", int'(remaining), 3 - i);
            if (i == 3) chk("ign_done", int'(done), 1);
            finish_tick();
        end

        // asynchronous reset mid-count
        start = 1'b1; load_val = 8'd3; cyc(1); start = 1'b0;
        rise4(); chk("arst_rem2", int'(remaining), 2);
        cyc(10);
        #2 rstn = 1'b0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_rem", int'(remaining), 0);
        chk("arst_pulse", int'(tick_pulse), 0);
        cyc(2);
        d0 = done_seen;
        rstn = 1'b1;
        cyc(20);
        tick_in = 1'b0;
        cyc(32);
        rise4(); finish_tick();
        rise4(); finish_tick();
        chk("arst_no_done", done_seen - d0, 0);
        chk("arst_idle", int'(busy), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/tick_timer.md
# tick_timer

Programmable interval timer that consumes the slow toggling output of the ripple divider stage and counts its rising edges in the system clock domain. It synchronises the divider output, converts each rising edge into a one-cycle `tick_pulse`, and runs a start/abort/done countdown of `load_val` ticks. Downstream control FSMs use it for human-scale delays without touching the divided clock directly.

## Interface
- `COUNT_W`, default 8: width of the tick count and `remaining`.
- `clk`  in  1  system clock, the same clock that drives the divider; all state updates on its rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `tick_in`  in  1  divider output (`Q_out`), treated as asynchronous; each rising edge counts as one tick.
- `start`  in  1  single-cycle request; sampled only in IDLE.
- `load_val`  in  COUNT_W  tick count captured when `start` is accepted.
- `abort`  in  1  cancels a running count; no effect outside COUNT.
- `busy`  out  1  high in COUNT and DONE.
- `done`  out  1  one-cycle pulse at normal completion.
- `remaining`  out  COUNT_W  ticks left in the current count.
- `tick_pulse`  out  1  registered one-cycle pulse per `tick_in` rising edge, free-running in every state.

## Operation
- **Synchroniser.**
  - Two flops (`s1`, `s2`) feed an edge register `s2_d`.
  - `tick_pulse` is registered: next value is `s2 & ~s2_d & primed`.
- **Warm-up.**
  - `primed` is set by a 2-bit warm-up counter, 2 cycles after reset release.
  - While `primed` is low, no `tick_pulse` is produced. This blocks a spurious tick when `tick_in` is already high at reset release.
- **FSM states.**
  - **IDLE:**
    - `start=1` with `load_val≠0`: capture `remaining <= load_val`, go to COUNT.
    - `start=1` with `load_val=0`: go to DONE; `remaining` stays 0.
  - **COUNT:**
    - `abort=1`: go to IDLE, `remaining <= 0`, no `done`. `abort` takes priority over a simultaneous tick.
    - Otherwise `tick_pulse=1` decrements `remaining`.
    - `tick_pulse=1` with `remaining=1`: `remaining <= 0` and go to DONE.
    - `start` is ignored.
  - **DONE:**
    - `done=1`, `busy=1` for exactly one cycle, then unconditionally IDLE.
    - `start` and `abort` are ignored.
- **Outputs.** `done` and `busy` are Moore outputs decoded from the state register. `remaining` is a register.
- **Arithmetic.** Unsigned, COUNT_W bits. `remaining` never decrements below 0; there is no wrap-around.

## Timing
- **Reset values:** `s1`, `s2`, `s2_d`, `tick_pulse`, `primed`, warm-up counter = 0; state = IDLE; `remaining` = 0; `busy` = 0; `done` = 0.
- **Reset mid-count:** forces all reset values immediately and asynchronously; no `done` is produced.
- **Tick latency:** a `tick_in` rise that meets setup before clk edge k gives `tick_pulse` high during the cycle after edge k+2 (3 edges). The decrement takes effect at edge k+3.
- **Start latency:** `start` accepted at edge e gives `busy=1` from edge e. With `load_val=0`, `done` is high in the cycle after edge e.
- **Completion:** the tick that drives `remaining` 1→0 moves the FSM to DONE on that same edge. `done` is high in the following cycle and `busy` drops one cycle later.
- **Tick rate:** `tick_in` high and low phases are each ≥3 clk cycles; the divide-by-64 source guarantees 32. Faster toggling is out of spec.
- **Back-to-back:** a new `start` is accepted in the first IDLE cycle after DONE.

## Structure
- **Package `tick_timer_pkg`:**
  - state enum `{IDLE, COUNT, DONE}`, 2 bits;
  - `WARMUP_CYCLES = 2`;
  - `SYNC_STAGES = 2`.
- **Sub-module `tick_sync`:**
  - Contains the synchroniser, warm-up gate and edge detector.
  - Ports: `clk`, `rstn`, `tick_in`, `tick_pulse`.
  - Reusable by other consumers of the divider output.
- **Top `tick_timer`:** instantiates `tick_sync` plus the FSM and countdown register.

## Test plan
- **Reset behaviour:** `tick_in` held high through reset, then released → no `tick_pulse` for 10 cycles; all outputs 0.
- **Normal count:** `start` with `load_val=3`, `tick_in` toggling every 32 clks → `remaining` steps 3,2,1,0, each at the edge after its `tick_pulse`. `done` is high for exactly one cycle after the 3rd tick; `busy` is high from the start edge through the `done` cycle.
- **Zero load:** `start` with `load_val=0` → `done` high the next cycle; `remaining` stays 0; `busy` high 1 cycle.
- **Abort:** `load_val=5`, `abort` asserted in the same cycle as the 2nd `tick_pulse` → IDLE, `remaining=0`, no `done`. A following `start` with `load_val=1` completes after 1 tick.
- **Ignored start:** `start` with `load_val=9` while COUNT has `remaining=4` → ignored; `remaining` continues 4→0 and `done` follows the 4th tick.
- **Async reset mid-count:** `rstn` low mid-COUNT with `remaining=2` → outputs 0 immediately. After release, `done` never pulses without a new `start`.
